// File: rtl/display_scan_ctrl_pkg.sv
// rtl/display_scan_ctrl_pkg.sv - shared types and constants for the multiplexed display scanner
package display_scan_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } upd_state_e;

  localparam int          NUM_DIGITS = 4;
  localparam int          DIG_W      = 2;
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;

  function automatic logic [NUM_DIGITS-1:0] dig_onehot(input logic [DIG_W-1:0] idx);
    logic [NUM_DIGITS-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_decoder.sv
// rtl/display_scan_ctrl_decoder.sv - shared hex to active-low seven-segment decoder {g,f,e,d,c,b,a}
module BinaryToSevenSegOpt_GL (
  input  logic [3:0] bin_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (bin_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit scanned display with frame-aligned double-buffered updates
// Optional leading-zero blanking: define DISPLAY_SCAN_CTRL_LZB_EN.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [15:0] in_data,
  output logic [3:0]  digit_sel,
  output logic [6:0]  seg
);

  localparam logic [15:0]      CNT_MAX = 16'(REFRESH_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(NUM_DIGITS - 1);

  upd_state_e       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      disp_q, disp_d;

  logic             cnt_wrap;
  logic             frame_end;
  logic             accept;
  logic             commit;
  logic [3:0]       cur_nib;
  logic [6:0]       dec_seg;
  logic             blank_digit;

  assign cnt_wrap  = en && (cnt_q == CNT_MAX);
  assign frame_end = cnt_wrap && (dig_q == DIG_MAX);
  assign accept    = in_val && in_rdy;
  assign commit    = (state_q == ST_PEND) && frame_end;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PEND;
      ST_PEND: if (frame_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_rdy = 1'b0;
    case (state_q)
      ST_IDLE: in_rdy = 1'b1;
      ST_PEND: in_rdy = 1'b0;
      default: in_rdy = 1'b0;
    endcase
  end

  // Scan counters freeze whenever the display is disabled
  always_comb begin
    cnt_d = cnt_q;
    dig_d = dig_q;
    if (en) begin
      if (cnt_wrap) begin
        cnt_d = '0;
        dig_d = dig_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    disp_d   = disp_q;
    if (accept) shadow_d = in_data;
    if (commit) disp_d = shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      dig_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    case (dig_q)
      2'd0: cur_nib = disp_q[3:0];
      2'd1: cur_nib = disp_q[7:4];
      2'd2: cur_nib = disp_q[11:8];
      2'd3: cur_nib = disp_q[15:12];
      default: cur_nib = 4'h0;
    endcase
  end

  BinaryToSevenSegOpt_GL u_dec (
    .bin_i (cur_nib),
    .seg_o (dec_seg)
  );

`ifdef DISPLAY_SCAN_CTRL_LZB_EN
  // A digit is blanked only if it and every digit to its left are zero
  always_comb begin
    blank_digit = 1'b0;
    case (dig_q)
      2'd3: blank_digit = (disp_q[15:12] == 4'h0);
      2'd2: blank_digit = (disp_q[15:8] == 8'h00);
      2'd1: blank_digit = (disp_q[15:4] == 12'h000);
      default: blank_digit = 1'b0;
    endcase
  end
`else
  assign blank_digit = 1'b0;
`endif

  always_comb begin
    digit_sel = 4'b0000;
    seg       = SEG_BLANK;
    if (en) begin
      digit_sel = dig_onehot(dig_q);
      seg       = blank_digit ? SEG_BLANK : dec_seg;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl against a frame-level model
module tb_display_scan_ctrl;

  localparam int RC    = 4;
  localparam int FRAME = 4 * RC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [15:0] in_data = 16'h0;
  logic [3:0]  digit_sel;
  logic [6:0]  seg;

  int vectors = 0;
  int miscompares = 0;

  // Reference: time counted in enabled cycles since reset
  int          m_t;
  bit          m_pend;
  logic [15:0] m_shadow;
  logic [15:0] m_disp;
  logic [6:0]  seg_tab [16];

  display_scan_ctrl #(.REFRESH_CYCLES(RC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .digit_sel (digit_sel),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg();
    int   d;
    logic [3:0] nib;
    bit   blank;
    d = (m_t / RC) % 4;
    nib = 4'((m_disp >> (4 * d)) & 16'hF);
    blank = 1'b0;
`ifdef DISPLAY_SCAN_CTRL_LZB_EN
    if (d > 0 && (m_disp >> (4 * d)) == 16'h0) blank = 1'b1;
`endif
    if (!en || blank) return 7'b1111111;
    return seg_tab[nib];
  endfunction

  function automatic logic [3:0] exp_sel();
    if (!en) return 4'b0000;
    return 4'(1 << ((m_t / RC) % 4));
  endfunction

  task automatic check(input string tag);
    logic [3:0] es;
    logic [6:0] eg;
    logic       er;
    es = exp_sel();
    eg = exp_seg();
    er = !m_pend;
    vectors++;
    assert (digit_sel === es) else begin
      miscompares++;
      $error("FAIL %s digit_sel got %b exp %b (t=%0d)", tag, digit_sel, es, m_t);
    end
    assert (seg === eg) else begin
      miscompares++;
      $error("FAIL %s seg got %b exp %b (t=%0d)", tag, seg, eg, m_t);
    end
    assert (in_rdy === er) else begin
      miscompares++;
      $error("FAIL %s in_rdy got %b exp %b (t=%0d)", tag, in_rdy, er, m_t);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_pend = 1'b0;
    m_shadow = 16'h0;
    m_disp = 16'h0;
  endtask

  // Called at negedge; leaves the bench at the next negedge
  task automatic step(input logic e, input logic v, input logic [15:0] d, input string tag);
    bit fb;
    en = e;
    in_val = v;
    in_data = d;
    #1;
    check(tag);
    @(posedge clk);
    fb = e && ((m_t % FRAME) == FRAME - 1);
    if (m_pend) begin
      if (fb) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
    end else if (v) begin
      m_shadow = d;
      m_pend = 1'b1;
    end
    if (e) m_t++;
    @(negedge clk);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_frame_start(input string tag);
    for (int i = 0; i < 3 * FRAME && (m_t % FRAME) != 0; i++) step(1'b1, 1'b0, 16'h0, tag);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    model_reset();

    @(negedge clk);
    en = 1'b1;
    #1;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, "idle_scan");
    step(1'b1, 1'b1, 16'h1234, "accept_1234");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'hFFFF, "pend_ignore");
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 16'hFFFF, "commit_1234");

    run_to_frame_start("align");
    for (int i = 0; i < 2 * RC + 1; i++) step(1'b1, 1'b0, 16'h0, "to_digit2");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, "en_off");
    for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, 16'h0, "resume");

    step(1'b0, 1'b1, 16'h9876, "accept_while_off");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, "pend_while_off");
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 16'h0, "commit_after_on");

    // Accept coinciding with a frame boundary is committed one frame later
    for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != FRAME - 1; i++) step(1'b1, 1'b0, 16'h0, "to_boundary");
    step(1'b1, 1'b1, 16'hC0DE, "accept_at_boundary");
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 16'h0, "late_commit");

    step(1'b1, 1'b1, 16'hABCD, "accept_abcd");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, "pend_abcd");
    pulse_reset("reset_in_pend");
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 16'h0, "after_reset");

    run_to_frame_start("align2");
    step(1'b1, 1'b1, 16'h0050, "load_0050");
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 16'h0, "show_0050");
    step(1'b1, 1'b1, 16'h0000, "load_0000");
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 16'h0, "show_0000");
    step(1'b1, 1'b1, 16'h0709, "load_0709");
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 16'h0, "show_0709");

    for (int i = 0; i < 600; i++) begin
      logic e;
      logic v;
      logic [15:0] d;
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 7) == 0);
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = d & 16'h00FF;
      step(e, v, d, "random");
      if (i == 300) pulse_reset("random_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter: REFRESH_CYCLES, default 1000, number of clk cycles each digit is driven; legal range 2..65535.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  display enable; 0 blanks all digits and freezes the scan.
REQ-006 in_val  input  1  update request; in_data is valid.
REQ-007 in_rdy  output  1  controller can accept an update.
REQ-008 in_data  input  16  four 4-bit digits; [3:0] is digit 0, the rightmost digit.
REQ-009 digit_sel  output  4  one-hot, active-high digit enable; bit i drives digit i.
REQ-010 seg  output  7  active-low segments {g,f,e,d,c,b,a} for the selected digit.

Function
REQ-011 An update SHALL be accepted on any rising edge where in_val && in_rdy; in_data is captured into shadow register.
REQ-012 Update FSM SHALL have states IDLE (in_rdy=1) and PEND (in_rdy=0).
  - IDLE -> PEND on accept.
  - PEND -> IDLE on frame boundary; display register <= shadow on that edge.
REQ-013 Refresh counter SHALL count 0..REFRESH_CYCLES-1 while en=1, then wrap to 0; digit index (2 bits) SHALL increment on each wrap, 3 -> 0.
REQ-014 Frame boundary SHALL be the cycle where counter = REFRESH_CYCLES-1 and digit index = 3 and en=1.
REQ-015 Display register SHALL change only at a frame boundary, so a frame never mixes old and new digits.
REQ-016 An accept on the same edge as a frame boundary in IDLE SHALL move to PEND; the commit SHALL occur at the following frame boundary.
REQ-017 in_val held high while in_rdy=0 SHALL be ignored; in_data changes in PEND SHALL have no effect.
REQ-018 With en=1: digit_sel = one-hot(digit index); seg = decode(display nibble[digit index]) through the shared decoder.
REQ-019 With en=0:
  - digit_sel = 4'b0000 and seg = 7'b1111111.
  - counter and digit index SHALL hold.
  - update accept SHALL still operate; a pending commit waits until en returns to 1.
REQ-020 Outputs SHALL be combinational from registered state only, with no path from in_* to seg or digit_sel.
REQ-021 Decoder mapping (0..9 display; A..F) SHALL match the shared decoder exactly; e.g. 0 -> 7'b1000000, 1 -> 7'b1111001.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately set:
  - counter=0, digit index=0, FSM=IDLE.
  - display and shadow registers to 16'h0000.
  - in_rdy=1.
REQ-023 Reset mid-frame or in PEND SHALL discard the pending update; after release, digit 0 SHALL be driven showing 0 (if en=1).

Configuration
REQ-024 Macro DISPLAY_SCAN_CTRL_LZB_EN defined: leading-zero blanking is compiled in.
  - Digits 3..1 that are 0 and above the most-significant non-zero digit SHALL output seg=7'b1111111, with digit_sel still asserted.
  - Digit 0 is never blanked.
REQ-025 Macro undefined: all four digits SHALL always be decoded and no blanking logic is present.

Structure
REQ-026 Shared package SHALL hold:
  - FSM state typedef (IDLE, PEND).
  - SEG_BLANK = 7'b1111111.
  - NUM_DIGITS = 4.
  - digit-index width constant.
REQ-027 Exactly one sub-module instance SHALL exist: BinaryToSevenSegOpt_GL, the shared decoder, fed by a 4-bit mux of the display register.

Verification (REFRESH_CYCLES=4 unless noted)
REQ-028 Reset, en=1, no update -> digit_sel cycles 0001,0010,0100,1000 every 4 cycles; seg=7'b1000000 throughout.
REQ-029 Accept in_data=16'h1234 at cycle 5 -> in_rdy=0 until frame boundary at cycle 15; from cycle 16, digit 0 shows 4 (7'b0011001) and digit 3 shows 1.
REQ-030 Second in_val with 16'hFFFF while PEND -> ignored; display becomes the first value only.
REQ-031 en=0 for 10 cycles mid-digit 2 -> outputs blank and all-off; scan resumes at digit 2 with the same counter value.
REQ-032 rst_n pulsed low while PEND with 16'hABCD -> display=0, in_rdy=1 immediately, and the update is never committed.
REQ-033 With DISPLAY_SCAN_CTRL_LZB_EN defined, load 16'h0050 -> digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0; load 16'h0000 -> only digit 0 shows 0.
